// File: rtl/cache_pkg.sv
// ============================================================================
//  Module      : cache_pkg
//  Description : Shared types and constants for the cache / backing-RAM
//                slice. Holds the backing RAM controller state encoding and
//                the width of its latency down-counter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cache_pkg;

  // Backing RAM request sequencing states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RESPOND = 2'd2
  } ram_state_t;

  // Width of the latency down-counter; latencies up to 255 are legal.
  localparam int LATENCY_WIDTH = 8;

endpackage : cache_pkg

`default_nettype wire

// File: rtl/backing_ram.sv
// ============================================================================
//  Module      : backing_ram
//  Description : Word-organised backing memory behind the cache, with a fixed
//                programmable read / write latency and a non-pipelined
//                strobe handshake. Completion is signalled by a one-cycle
//                ram_data_valid pulse; protocol violations set a sticky
//                ram_error flag.
//  Ports       :
//    clk            - sole clock, rising edge
//    rst            - synchronous active-high reset
//    ram_address    - byte address (bits [1:0] ignored)
//    ram_rd         - read request strobe
//    ram_wr         - write request strobe
//    ram_data_wr    - write data
//    ram_data_rd    - read data, non-zero only in the valid cycle of a read
//    ram_data_valid - one-cycle completion pulse (reads and writes)
//    ram_error      - sticky protocol-violation flag, cleared by reset
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module backing_ram
  import cache_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [ADDRESS_WIDTH-1:0] ram_address,
  input  logic                     ram_rd,
  input  logic                     ram_wr,
  input  logic [31:0]              ram_data_wr,
  output logic [31:0]              ram_data_rd,
  output logic                     ram_data_valid,
  output logic                     ram_error
);

  localparam int WORD_BITS = ADDRESS_WIDTH - 2;
  localparam int DEPTH     = 1 << WORD_BITS;

  // Counter load values: the accepting edge itself counts as the first
  // latency edge, so the counter starts at latency-1.
  localparam logic [LATENCY_WIDTH-1:0] READ_LOAD  = LATENCY_WIDTH'(READ_LATENCY - 1);
  localparam logic [LATENCY_WIDTH-1:0] WRITE_LOAD = LATENCY_WIDTH'(WRITE_LATENCY - 1);

  // Array contents are never reset.
  logic [31:0] mem [DEPTH];

  ram_state_t               state;
  ram_state_t               state_next;
  logic [LATENCY_WIDTH-1:0] count;
  logic [WORD_BITS-1:0]     op_addr;
  logic [31:0]              op_wdata;
  logic                     op_is_write;

  logic                     accept;
  logic [LATENCY_WIDTH-1:0] load_value;
  logic                     respond;
  logic                     commit_write;
  logic                     deliver_read;
  logic                     error_event;

  // Byte-offset bits carry no meaning for a word memory.
  logic unused_byte_offset;
  assign unused_byte_offset = ^ram_address[1:0];

  // Exactly one strobe in IDLE is a legal request; both at once is rejected.
  assign accept     = (state == IDLE) && (ram_rd ^ ram_wr);
  assign load_value = ram_wr ? WRITE_LOAD : READ_LOAD;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        // Latency 1 needs no waiting, so BUSY is skipped entirely.
        if (accept) begin
          state_next = (load_value == '0) ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (count <= LATENCY_WIDTH'(1)) begin
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Output decode
  // -------------------------------------------------------------------------
  always_comb begin
    respond      = (state == RESPOND);
    commit_write = respond && op_is_write;
    deliver_read = respond && !op_is_write;
    error_event  = ((state == IDLE) && ram_rd && ram_wr) ||
                   ((state == BUSY) && (ram_rd || ram_wr));
  end

  // Request capture; only meaningful once a request has been accepted.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_addr     <= ram_address[ADDRESS_WIDTH-1:2];
      op_wdata    <= ram_data_wr;
      op_is_write <= ram_wr;
    end
  end

  // Counter, response and error registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      count          <= '0;
      ram_data_valid <= 1'b0;
      ram_data_rd    <= '0;
      ram_error      <= 1'b0;
    end else begin
      if (accept) begin
        count <= load_value;
      end else if ((state == BUSY) && (count != '0)) begin
        count <= count - LATENCY_WIDTH'(1);
      end
      // The edge leaving RESPOND is the one that completes the request.
      ram_data_valid <= respond;
      ram_data_rd    <= deliver_read ? mem[op_addr] : '0;
      if (error_event) begin
        ram_error <= 1'b1;
      end
    end
  end

  // Write commit coincides with the valid pulse; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && commit_write) begin
      mem[op_addr] <= op_wdata;
    end
  end

endmodule : backing_ram

`default_nettype wire

// File: tb/tb_backing_ram.sv
// ============================================================================
//  Module      : tb_backing_ram
//  Description : Self-checking bench for backing_ram. Instance 0 uses
//                read/write latency 4/4, instance 1 uses 1/2. Expected data
//                comes from a word-indexed associative model, expected
//                latencies from the instance parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_backing_ram;

  logic              clk;
  logic              rst;
  logic [1:0][15:0]  addr;
  logic [1:0]        rd;
  logic [1:0]        wr;
  logic [1:0][31:0]  wdata;
  logic [1:0][31:0]  rdata;
  logic [1:0]        valid;
  logic [1:0]        err;

  int n_cmp  = 0;
  int n_fail = 0;

  int exp_rl [2] = '{4, 1};
  int exp_wl [2] = '{4, 2};

  // Reference memory: key = instance * 65536 + word index.
  bit [31:0] mdl [int];

  backing_ram #(.ADDRESS_WIDTH(16), .READ_LATENCY(4), .WRITE_LATENCY(4)) dut0 (
    .clk(clk), .rst(rst), .ram_address(addr[0]), .ram_rd(rd[0]), .ram_wr(wr[0]),
    .ram_data_wr(wdata[0]), .ram_data_rd(rdata[0]), .ram_data_valid(valid[0]),
    .ram_error(err[0])
  );

  backing_ram #(.ADDRESS_WIDTH(16), .READ_LATENCY(1), .WRITE_LATENCY(2)) dut1 (
    .clk(clk), .rst(rst), .ram_address(addr[1]), .ram_rd(rd[1]), .ram_wr(wr[1]),
    .ram_data_wr(wdata[1]), .ram_data_rd(rdata[1]), .ram_data_valid(valid[1]),
    .ram_error(err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int key(input int sel, input logic [15:0] a);
    return sel * 65536 + int'(a[15:2]);
  endfunction

  // Issue one request from the current cycle; returns edges from accept to valid.
  task automatic do_op(input int sel, input bit is_wr, input logic [15:0] a,
                       input logic [31:0] d, output logic [31:0] q, output int lat);
    addr[sel]  = a;
    wdata[sel] = d;
    rd[sel]    = !is_wr;
    wr[sel]    = is_wr;
    @(posedge clk); #1;
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
    lat = 0;
    while (valid[sel] !== 1'b1 && lat < 300) begin
      @(posedge clk); #1;
      lat++;
    end
    q = rdata[sel];
    if (is_wr) mdl[key(sel, a)] = d;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(3);
    for (int s = 0; s < 2; s++) begin
      n_cmp++; if (valid[s] !== 1'b0) begin n_fail++; $display("FAIL reset_valid[%0d]: got %b expected 0", s, valid[s]); end
      n_cmp++; if (rdata[s] !== 32'h0) begin n_fail++; $display("FAIL reset_rdata[%0d]: got %h expected 0", s, rdata[s]); end
      n_cmp++; if (err[s] !== 1'b0) begin n_fail++; $display("FAIL reset_error[%0d]: got %b expected 0", s, err[s]); end
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] q;
    int lat;
    do_op(0, 1'b1, 16'h0010, 32'hDEADBEEF, q, lat);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL basic_wr_latency: got %0d expected 4", lat); end
    n_cmp++; if (q !== 32'h0) begin n_fail++; $display("FAIL basic_wr_rdata_zero: got %h expected 0", q); end
    do_op(0, 1'b0, 16'h0010, 32'h0, q, lat);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL basic_rd_latency: got %0d expected 4", lat); end
    n_cmp++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_rd_data: got %h expected deadbeef", q); end
    idle(1);
    n_cmp++; if (valid[0] !== 1'b0) begin n_fail++; $display("FAIL basic_pulse_width: got %b expected 0", valid[0]); end
    n_cmp++; if (rdata[0] !== 32'h0) begin n_fail++; $display("FAIL basic_rdata_idle: got %h expected 0", rdata[0]); end
    do_op(0, 1'b0, 16'h0013, 32'h0, q, lat);
    n_cmp++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL basic_byte_offset: got %h expected deadbeef", q); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q;
    int lat;
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1'b1, 16'(i * 4), $urandom, q, lat);
      n_cmp++; if (lat != exp_wl[1]) begin n_fail++; $display("FAIL b2b_preload_latency: got %0d expected %0d", lat, exp_wl[1]); end
    end
    // Line fill: each strobe issued in the cycle the previous valid is seen.
    for (int i = 0; i < 4; i++) begin
      do_op(1, 1'b0, 16'(i * 4), 32'h0, q, lat);
      n_cmp++; if (lat != exp_rl[1]) begin n_fail++; $display("FAIL b2b_rd_latency[%0d]: got %0d expected %0d", i, lat, exp_rl[1]); end
      n_cmp++; if (q !== mdl[key(1, 16'(i * 4))]) begin n_fail++; $display("FAIL b2b_rd_data[%0d]: got %h expected %h", i, q, mdl[key(1, 16'(i * 4))]); end
    end
    idle(2);
  endtask

  task automatic test_error();
    bit saw;
    int cnt;
    // Both strobes in IDLE: rejected, flags error.
    addr[0] = 16'h0010; rd[0] = 1'b1; wr[0] = 1'b1;
    @(posedge clk); #1;
    rd[0] = 1'b0; wr[0] = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (valid[0] === 1'b1) saw = 1'b1;
      idle(1);
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL err_both_no_valid: got %b expected 0", saw); end
    n_cmp++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL err_both_sticky: got %b expected 1", err[0]); end
    n_cmp++; if (err[1] !== 1'b0) begin n_fail++; $display("FAIL err_other_clear: got %b expected 0", err[1]); end
    rst = 1'b1; idle(1); rst = 1'b0;
    n_cmp++; if (err[0] !== 1'b0) begin n_fail++; $display("FAIL err_cleared_by_reset: got %b expected 0", err[0]); end
    // Strobe during BUSY: flags error, is not queued, original op unaffected.
    addr[0] = 16'h0040; wdata[0] = 32'hA5A5_0F0F; wr[0] = 1'b1;
    @(posedge clk); #1;
    wr[0] = 1'b0; rd[0] = 1'b1; addr[0] = 16'h0044;
    @(posedge clk); #1;
    rd[0] = 1'b0;
    cnt = 1;
    while (valid[0] !== 1'b1 && cnt < 300) begin idle(1); cnt++; end
    mdl[key(0, 16'h0040)] = 32'hA5A5_0F0F;
    n_cmp++; if (cnt != 4) begin n_fail++; $display("FAIL err_busy_latency: got %0d expected 4", cnt); end
    n_cmp++; if (err[0] !== 1'b1) begin n_fail++; $display("FAIL err_busy_flag: got %b expected 1", err[0]); end
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      idle(1);
      if (valid[0] === 1'b1) saw = 1'b1;
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL err_busy_not_queued: got %b expected 0", saw); end
    rst = 1'b1; idle(1); rst = 1'b0;
  endtask

  task automatic test_reset_abort();
    logic [31:0] q;
    int lat;
    bit saw;
    do_op(0, 1'b1, 16'h0020, 32'h1111_1111, q, lat);
    n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL abort_prior_wr_latency: got %0d expected 4", lat); end
    addr[0] = 16'h0020; wdata[0] = 32'h1234_5678; wr[0] = 1'b1;
    @(posedge clk); #1;           // accepting edge
    wr[0] = 1'b0;
    idle(1);                      // accept+1
    rst = 1'b1;
    idle(1);                      // accept+2 sees reset
    rst = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (valid[0] === 1'b1) saw = 1'b1;
      idle(1);
    end
    n_cmp++; if (saw !== 1'b0) begin n_fail++; $display("FAIL abort_no_valid: got %b expected 0", saw); end
    do_op(0, 1'b0, 16'h0020, 32'h0, q, lat);
    n_cmp++; if (q !== 32'h1111_1111) begin n_fail++; $display("FAIL abort_not_committed: got %h expected 11111111", q); end
  endtask

  task automatic test_eviction();
    logic [31:0] q;
    int lat;
    // Memory already holds the incoming line (same index 1, different tag).
    for (int i = 0; i < 4; i++) do_op(0, 1'b1, 16'(16'h0110 + i * 4), $urandom, q, lat);
    // Dirty line writeback followed by the refill.
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b1, 16'(16'h0010 + i * 4), $urandom, q, lat);
      n_cmp++; if (lat != 4) begin n_fail++; $display("FAIL evict_wb_latency[%0d]: got %0d expected 4", i, lat); end
    end
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b0, 16'(16'h0110 + i * 4), 32'h0, q, lat);
      n_cmp++; if (q !== mdl[key(0, 16'(16'h0110 + i * 4))]) begin n_fail++; $display("FAIL evict_fill[%0d]: got %h expected %h", i, q, mdl[key(0, 16'(16'h0110 + i * 4))]); end
    end
    for (int i = 0; i < 4; i++) begin
      do_op(0, 1'b0, 16'(16'h0010 + i * 4), 32'h0, q, lat);
      n_cmp++; if (q !== mdl[key(0, 16'(16'h0010 + i * 4))]) begin n_fail++; $display("FAIL evict_mem_holds[%0d]: got %h expected %h", i, q, mdl[key(0, 16'(16'h0010 + i * 4))]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] q;
    logic [15:0] a;
    int lat;
    bit is_wr;
    for (int s = 0; s < 2; s++) begin
      for (int w = 0; w < 32; w++) do_op(s, 1'b1, 16'(16'h0200 + w * 4), $urandom, q, lat);
      for (int n = 0; n < 60; n++) begin
        is_wr = 1'($urandom_range(0, 1));
        a = 16'(16'h0200 + $urandom_range(0, 31) * 4 + $urandom_range(0, 3));
        if (is_wr) begin
          do_op(s, 1'b1, a, $urandom, q, lat);
          n_cmp++; if (lat != exp_wl[s]) begin n_fail++; $display("FAIL rand_wr_latency[%0d]: got %0d expected %0d", s, lat, exp_wl[s]); end
        end else begin
          do_op(s, 1'b0, a, 32'h0, q, lat);
          n_cmp++; if (lat != exp_rl[s]) begin n_fail++; $display("FAIL rand_rd_latency[%0d]: got %0d expected %0d", s, lat, exp_rl[s]); end
          n_cmp++; if (q !== mdl[key(s, a)]) begin n_fail++; $display("FAIL rand_rd_data[%0d] @%h: got %h expected %h", s, a, q, mdl[key(s, a)]); end
        end
      end
      idle(2);
    end
  endtask

  initial begin
    rst   = 1'b1;
    addr  = '0;
    rd    = '0;
    wr    = '0;
    wdata = '0;
    @(posedge clk); #1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_error();
    test_reset_abort();
    test_eviction();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_backing_ram

`default_nettype wire
